// File: rtl/polyphase_pkg.sv
// polyphase_pkg: shared sizes, FSM states and odd-branch coefficients for the x2 half-band
// sample path (decimator and interpolator use the same table).
package polyphase_pkg;
    localparam int SAMPLE_WIDTH = 6;
    localparam int COEF_WIDTH   = 18;
    localparam int COEF_FRAC    = 17;
    localparam int BRANCH_TAPS  = 28;

    typedef enum logic [1:0] {IDLE, MAC, OUT_A, OUT_B} state_t;

    function automatic int acc_width(input int sw, input int cw, input int taps);
        return sw + cw + $clog2(taps);
    endfunction

    localparam int ACC_WIDTH = acc_width(SAMPLE_WIDTH, COEF_WIDTH, BRANCH_TAPS);

    // Hann-windowed half-sample sinc; symmetric, sums to exactly 2^COEF_FRAC
    localparam logic signed [COEF_WIDTH-1:0] COEF [BRANCH_TAPS] = '{
        -18'sd10,    18'sd94,     -18'sd278,   18'sd582,    -18'sd1028,  18'sd1644,  -18'sd2470,
        18'sd3569,   -18'sd5045,  18'sd7102,   -18'sd10175, 18'sd15411,  -18'sd27032, 18'sd83172,
        18'sd83172,  -18'sd27032, 18'sd15411,  -18'sd10175, 18'sd7102,   -18'sd5045,  18'sd3569,
        -18'sd2470,  18'sd1644,   -18'sd1028,  18'sd582,    -18'sd278,   18'sd94,     -18'sd10
    };
endpackage

// File: rtl/halfband_mac.sv
// halfband_mac: registered signed multiply-accumulate, one product per enabled cycle.
module halfband_mac #(
    parameter int SW = 6,
    parameter int CW = 18,
    parameter int AW = 29
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic signed [SW-1:0] sample_i,
    input  logic signed [CW-1:0] coef_i,
    output logic signed [AW-1:0] acc_o
);
    logic signed [SW+CW-1:0] prod;
    logic signed [AW-1:0]    acc_q, acc_d;

    assign prod  = sample_i * coef_i;
    assign acc_d = clr_i ? '0 : en_i ? acc_q + AW'(prod) : acc_q;
    assign acc_o = acc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) acc_q <= '0;
        else          acc_q <= acc_d;
    end
endmodule

// File: rtl/polyphase_halfband_interp.sv
// polyphase_halfband_interp: x2 half-band interpolator; every accepted input yields an
// interpolated half-sample value (phase A) followed by the delayed input itself (phase B).
module polyphase_halfband_interp
    import polyphase_pkg::*;
(
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           valid_in,
    output logic                           ready_in,
    input  logic signed [SAMPLE_WIDTH-1:0] data_in,
    output logic                           valid_out,
    input  logic                           ready_out,
    output logic signed [SAMPLE_WIDTH-1:0] data_out,
    output logic                           phase_out
);
    localparam int TAP_W = $clog2(BRANCH_TAPS);
    localparam int MID   = BRANCH_TAPS / 2 - 1;
    localparam int RND_W = ACC_WIDTH + 1;
    localparam logic signed [RND_W-1:0] HALF_LSB = RND_W'(1) <<< (COEF_FRAC - 1);
    localparam logic signed [RND_W-1:0] SAT_MAX  = RND_W'(2 ** (SAMPLE_WIDTH - 1) - 1);
    localparam logic signed [RND_W-1:0] SAT_MIN  = RND_W'(-(2 ** (SAMPLE_WIDTH - 1)));

    state_t                         state_q, state_d;
    logic [TAP_W-1:0]               tap_q, tap_d;
    logic signed [SAMPLE_WIDTH-1:0] d_q [BRANCH_TAPS];
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [RND_W-1:0]        acc_rnd;
    logic signed [SAMPLE_WIDTH-1:0] interp;
    logic                           accept, last_tap;

    assign accept   = valid_in && ready_in;
    assign last_tap = tap_q == TAP_W'(BRANCH_TAPS - 1);
    assign acc_rnd  = (RND_W'(acc) + HALF_LSB) >>> COEF_FRAC;
    assign interp   = acc_rnd > SAT_MAX ? SAT_MAX[SAMPLE_WIDTH-1:0]
                    : acc_rnd < SAT_MIN ? SAT_MIN[SAMPLE_WIDTH-1:0]
                    : acc_rnd[SAMPLE_WIDTH-1:0];

    // One tap per MAC cycle; the accept edge clears the accumulator for the new sample
    halfband_mac #(.SW(SAMPLE_WIDTH), .CW(COEF_WIDTH), .AW(ACC_WIDTH)) u_mac (
        .clk,
        .reset_n,
        .clr_i    (accept),
        .en_i     (state_q == MAC),
        .sample_i (d_q[tap_q]),
        .coef_i   (COEF[tap_q]),
        .acc_o    (acc)
    );

    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        ready_in  = 1'b0;
        valid_out = 1'b0;
        phase_out = 1'b0;
        data_out  = '0;
        case (state_q)
            IDLE: begin
                ready_in = 1'b1;
                if (valid_in) begin
                    state_d = MAC;
                    tap_d   = '0;
                end
            end
            MAC: begin
                tap_d   = last_tap ? '0 : tap_q + 1'b1;
                state_d = last_tap ? OUT_A : MAC;
            end
            OUT_A: begin
                valid_out = 1'b1;
                data_out  = interp;
                state_d   = ready_out ? OUT_B : OUT_A;
            end
            OUT_B: begin
                valid_out = 1'b1;
                phase_out = 1'b1;
                data_out  = d_q[MID];
                state_d   = ready_out ? IDLE : OUT_B;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            tap_q   <= '0;
            for (int i = 0; i < BRANCH_TAPS; i++) d_q[i] <= '0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            if (accept) begin
                d_q[0] <= data_in;
                for (int i = 1; i < BRANCH_TAPS; i++) d_q[i] <= d_q[i-1];
            end
        end
    end
endmodule

// File: tb/tb_polyphase_halfband_interp.sv
// tb_polyphase_halfband_interp: randomized and directed checks of the x2 half-band
// interpolator against a sum-of-products reference model over the input history.
module tb_polyphase_halfband_interp;
    localparam int SW   = 6;
    localparam int BT   = 28;
    localparam int FRAC = 17;
    localparam int MID  = BT / 2 - 1;
    localparam int HALF_COEF [BT/2] = '{-10, 94, -278, 582, -1028, 1644, -2470,
                                        3569, -5045, 7102, -10175, 15411, -27032, 83172};

    logic clk = 1'b0, reset_n = 1'b0, valid_in = 1'b0, ready_out = 1'b0;
    logic ready_in, valid_out, phase_out;
    logic signed [SW-1:0] data_in = '0, data_out;
    int vectors = 0, miscompares = 0, cyc = 0;
    int coef [BT];
    int hist [BT];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    polyphase_halfband_interp dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .phase_out (phase_out)
    );

    function automatic int rand_sample();
        return int'($urandom_range(63, 0)) - 32;
    endfunction

    function automatic void model_push(input int x);
        for (int k = BT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < BT; k++) hist[k] = 0;
    endfunction

    // Interpolated value: sum of coef*history, round half up, clamp to the sample range
    function automatic int model_a();
        longint acc = 0;
        for (int k = 0; k < BT; k++) acc += longint'(coef[k]) * longint'(hist[k]);
        acc = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        return acc > 31 ? 31 : acc < -32 ? -32 : int'(acc);
    endfunction

    task automatic apply_reset();
        valid_in = 1'b0; ready_out = 1'b0; data_in = '0;
        @(negedge clk); reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_clear();
    endtask

    // Send one sample with ready_out high and capture both output phases
    task automatic do_pair(input int x, output int a, output int pa, output int b,
                           output int pb, output int lat, output bit ok);
        int n;
        ok = 1'b1; a = 0; pa = 0; b = 0; pb = 0;
        @(negedge clk);
        valid_in = 1'b1; data_in = SW'(x); ready_out = 1'b1;
        n = 0;
        while (!ready_in && n < 100) begin @(negedge clk); n++; end
        if (!ready_in) ok = 1'b0;
        @(posedge clk); #1 valid_in = 1'b0;
        model_push(x);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!valid_out && lat < 100);
        if (!valid_out) ok = 1'b0;
        a = int'(data_out); pa = int'(phase_out);
        @(negedge clk);
        if (!valid_out) ok = 1'b0;
        b = int'(data_out); pb = int'(phase_out);
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        vectors++; if (ready_in !== 1'b1) begin miscompares++; $display("FAIL reset_ready_in: got %b want 1", ready_in); end
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        vectors++; if (data_out !== 6'sd0) begin miscompares++; $display("FAIL reset_data_out: got %0d want 0", data_out); end
        vectors++; if (phase_out !== 1'b0) begin miscompares++; $display("FAIL reset_phase_out: got %b want 0", phase_out); end
    endtask

    task automatic test_impulse(input string tag);
        int a, pa, b, pb, lat;
        bit ok;
        for (int p = 1; p <= 41; p++) begin
            do_pair(p == 1 ? 31 : 0, a, pa, b, pb, lat, ok);
            vectors++;
            if (!ok || lat != BT + 1) begin
                miscompares++; $display("FAIL %s_latency pair %0d: got %0d want %0d (handshake ok=%0b)", tag, p, lat, BT + 1, ok);
            end
            vectors++;
            if (a != model_a() || pa != 0) begin
                miscompares++; $display("FAIL %s_phase_a pair %0d: got %0d ph%0d want %0d ph0", tag, p, a, pa, model_a());
            end
            vectors++;
            if (b != (p == 14 ? 31 : 0) || pb != 1) begin
                miscompares++; $display("FAIL %s_phase_b pair %0d: got %0d ph%0d want %0d ph1", tag, p, b, pb, p == 14 ? 31 : 0);
            end
        end
    endtask

    task automatic test_dc();
        int a, pa, b, pb, lat, lv;
        bit ok;
        for (int s = 0; s < 2; s++) begin
            lv = s == 0 ? 16 : -32;
            for (int p = 1; p <= 40; p++) begin
                do_pair(lv, a, pa, b, pb, lat, ok);
                vectors++;
                if (!ok || a != model_a() || b != hist[MID]) begin
                    miscompares++; $display("FAIL dc_model level %0d pair %0d: got A=%0d B=%0d want A=%0d B=%0d", lv, p, a, b, model_a(), hist[MID]);
                end
                if (p >= BT) begin
                    vectors++;
                    if (a != lv || b != lv) begin
                        miscompares++; $display("FAIL dc_exact level %0d pair %0d: got A=%0d B=%0d want %0d", lv, p, a, b, lv);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        int a, pa, b, pb, lat;
        bit ok;
        for (int p = 1; p <= 48; p++) begin
            do_pair(p <= BT ? -32 : 31, a, pa, b, pb, lat, ok);
            vectors++;
            if (!ok || a != model_a() || b != hist[MID]) begin
                miscompares++; $display("FAIL sat_model pair %0d: got A=%0d B=%0d want A=%0d B=%0d", p, a, b, model_a(), hist[MID]);
            end
            if (p == BT + 15) begin
                vectors++;
                if (a != 31) begin miscompares++; $display("FAIL sat_overshoot pair %0d: got %0d want 31", p, a); end
            end
        end
    endtask

    task automatic test_random();
        int a, pa, b, pb, lat;
        bit ok;
        for (int p = 0; p < 60; p++) begin
            do_pair(rand_sample(), a, pa, b, pb, lat, ok);
            vectors++;
            if (!ok || a != model_a() || pa != 0 || b != hist[MID] || pb != 1) begin
                miscompares++; $display("FAIL random pair %0d: got A=%0d ph%0d B=%0d ph%0d want A=%0d ph0 B=%0d ph1", p, a, pa, b, pb, model_a(), hist[MID]);
            end
        end
    endtask

    task automatic test_stall();
        int x, y, a0, n;
        x = rand_sample(); y = rand_sample();
        @(negedge clk); valid_in = 1'b1; data_in = SW'(x); ready_out = 1'b0;
        n = 0;
        while (!ready_in && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 data_in = SW'(y);
        model_push(x);
        n = 0;
        while (!valid_out && n < 100) begin @(negedge clk); n++; end
        a0 = int'(data_out);
        vectors++;
        if (!valid_out || phase_out !== 1'b0 || a0 != model_a()) begin
            miscompares++; $display("FAIL stall_first_a: got %0d valid %b ph %b want %0d valid 1 ph 0", a0, valid_out, phase_out, model_a());
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (!valid_out || phase_out || ready_in || int'(data_out) != a0) begin
                miscompares++; $display("FAIL stall_hold cycle %0d: got %0d ph %b valid %b ready_in %b want %0d ph 0 valid 1 ready_in 0", i, data_out, phase_out, valid_out, ready_in, a0);
            end
        end
        ready_out = 1'b1;
        @(negedge clk);
        vectors++;
        if (!valid_out || !phase_out || int'(data_out) != hist[MID]) begin
            miscompares++; $display("FAIL stall_b: got %0d ph %b want %0d ph 1", data_out, phase_out, hist[MID]);
        end
        n = 0;
        while (!ready_in && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 valid_in = 1'b0;
        model_push(y);
        n = 0;
        do begin @(negedge clk); n++; end while (!valid_out && n < 100);
        vectors++;
        if (n != BT + 1 || phase_out || int'(data_out) != model_a()) begin
            miscompares++; $display("FAIL stall_next_a: got %0d ph %b after %0d cycles want %0d ph 0 after %0d", data_out, phase_out, n, model_a(), BT + 1);
        end
        @(negedge clk);
        vectors++;
        if (!phase_out || int'(data_out) != hist[MID]) begin
            miscompares++; $display("FAIL stall_next_b: got %0d ph %b want %0d ph 1", data_out, phase_out, hist[MID]);
        end
        @(negedge clk);
        vectors++;
        if (!ready_in || valid_out) begin
            miscompares++; $display("FAIL stall_no_dup: got ready_in %b valid_out %b want 1 0", ready_in, valid_out);
        end
    endtask

    task automatic test_back_to_back();
        int x, n, t_prev;
        t_prev = 0;
        x = rand_sample();
        @(negedge clk); valid_in = 1'b1; data_in = SW'(x); ready_out = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!ready_in && n < 100) begin @(negedge clk); n++; end
            @(posedge clk); #1;
            model_push(x);
            if (i > 0) begin
                vectors++;
                if (cyc - t_prev != BT + 3) begin
                    miscompares++; $display("FAIL b2b_period sample %0d: got %0d cycles want %0d", i, cyc - t_prev, BT + 3);
                end
            end
            t_prev = cyc;
            x = rand_sample(); data_in = SW'(x);
            n = 0;
            while (!valid_out && n < 100) begin @(negedge clk); n++; end
            vectors++;
            if (!valid_out || phase_out || int'(data_out) != model_a()) begin
                miscompares++; $display("FAIL b2b_a sample %0d: got %0d ph %b want %0d ph 0", i, data_out, phase_out, model_a());
            end
            @(negedge clk);
            vectors++;
            if (!phase_out || int'(data_out) != hist[MID]) begin
                miscompares++; $display("FAIL b2b_b sample %0d: got %0d ph %b want %0d ph 1", i, data_out, phase_out, hist[MID]);
            end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_reset_mid_out();
        int n;
        @(negedge clk); valid_in = 1'b1; data_in = SW'(rand_sample()); ready_out = 1'b0;
        n = 0;
        while (!ready_in && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 valid_in = 1'b0;
        n = 0;
        while (!valid_out && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (!valid_out) begin miscompares++; $display("FAIL rst_out_reach: got valid_out %b want 1", valid_out); end
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (valid_out !== 1'b0 || data_out !== 6'sd0 || phase_out !== 1'b0 || ready_in !== 1'b1) begin
            miscompares++; $display("FAIL rst_out_async: got valid %b data %0d ph %b ready_in %b want 0 0 0 1", valid_out, data_out, phase_out, ready_in);
        end
        @(negedge clk); reset_n = 1'b1;
        model_clear();
        ready_out = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (valid_out !== 1'b0 || ready_in !== 1'b1) begin
            miscompares++; $display("FAIL rst_out_no_partial: got valid %b ready_in %b want 0 1", valid_out, ready_in);
        end
    endtask

    task automatic test_reset_mid_mac();
        int n;
        @(negedge clk); valid_in = 1'b1; data_in = SW'(rand_sample()); ready_out = 1'b1;
        n = 0;
        while (!ready_in && n < 100) begin @(negedge clk); n++; end
        @(posedge clk); #1 valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
            miscompares++; $display("FAIL rst_mac_async: got ready_in %b valid %b want 1 0", ready_in, valid_out);
        end
        #1 reset_n = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        vectors++;
        if (valid_out !== 1'b0) begin miscompares++; $display("FAIL rst_mac_no_partial: got valid %b want 0", valid_out); end
        test_impulse("impulse_after_reset");
    endtask

    initial begin
        for (int k = 0; k < BT / 2; k++) begin
            coef[k] = HALF_COEF[k];
            coef[BT-1-k] = HALF_COEF[k];
        end
        model_clear();
        test_reset();
        test_impulse("impulse");
        test_dc();
        test_saturation();
        test_random();
        test_stall();
        test_back_to_back();
        test_reset_mid_out();
        test_reset_mid_mac();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, %0d vectors applied, %0d miscompares so far", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end
endmodule
